wb_rr_arbiter: RTL and testbench



---
 rtl/wb_arb_pkg.sv | 32 +++
 rtl/wb_rr_arbiter_if.sv | 47 ++++
 rtl/wb_rr_arbiter_pick.sv | 20 ++
 rtl/wb_rr_arbiter.sv | 163 ++++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and the round-robin search used by the Wishbone arbiter.
package wb_arb_pkg;

  localparam int unsigned MAX_M     = 8;
  localparam int unsigned MAX_IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    TOERR = 2'd2
  } arb_state_e;

  // First set request bit searching upward from last+1 with wrap at n; one-hot result.
  function automatic logic [MAX_M-1:0] rr_search(input logic [MAX_M-1:0] req,
                                                 input int unsigned      last,
                                                 input int unsigned      n);
    logic [MAX_M-1:0]     gnt;
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_M; k++) begin
      idx = MAX_IDX_W'((last + k) % n);
      if ((k <= n) && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Bundle of all master-side and slave-side Wishbone signals around the arbiter.
interface wb_rr_arbiter_if #(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADR_W       = 64,
  parameter int unsigned DAT_W       = 64,
  parameter int unsigned SEL_W       = DAT_W / 8,
  parameter int unsigned TAG_W       = 1
);
  logic [NUM_MASTERS-1:0]       m_CYC_I, m_STB_I, m_WE_I, m_LOCK_I;
  logic [NUM_MASTERS*ADR_W-1:0] m_ADR_I;
  logic [NUM_MASTERS*DAT_W-1:0] m_DAT_I;
  logic [NUM_MASTERS*SEL_W-1:0] m_SEL_I;
  logic [NUM_MASTERS*TAG_W-1:0] m_TGA_I, m_TGC_I, m_TGD_I;
  logic [DAT_W-1:0]             m_DAT_O;
  logic [TAG_W-1:0]             m_TGD_O;
  logic [NUM_MASTERS-1:0]       m_ACK_O, m_ERR_O, m_RTY_O;

  logic                         s_CYC_O, s_STB_O, s_WE_O, s_LOCK_O;
  logic [ADR_W-1:0]             s_ADR_O;
  logic [DAT_W-1:0]             s_DAT_O;
  logic [SEL_W-1:0]             s_SEL_O;
  logic [TAG_W-1:0]             s_TGA_O, s_TGC_O, s_TGD_O;
  logic [DAT_W-1:0]             s_DAT_I;
  logic [TAG_W-1:0]             s_TGD_I;
  logic                         s_ACK_I, s_ERR_I, s_RTY_I;

  modport arb (
    input  m_CYC_I, m_STB_I, m_WE_I, m_LOCK_I, m_ADR_I, m_DAT_I, m_SEL_I,
           m_TGA_I, m_TGC_I, m_TGD_I,
    output m_DAT_O, m_TGD_O, m_ACK_O, m_ERR_O, m_RTY_O,
    output s_CYC_O, s_STB_O, s_WE_O, s_LOCK_O, s_ADR_O, s_DAT_O, s_SEL_O,
           s_TGA_O, s_TGC_O, s_TGD_O,
    input  s_DAT_I, s_TGD_I, s_ACK_I, s_ERR_I, s_RTY_I
  );

  modport master (
    output m_CYC_I, m_STB_I, m_WE_I, m_LOCK_I, m_ADR_I, m_DAT_I, m_SEL_I,
           m_TGA_I, m_TGC_I, m_TGD_I,
    input  m_DAT_O, m_TGD_O, m_ACK_O, m_ERR_O, m_RTY_O
  );

  modport slave (
    input  s_CYC_O, s_STB_O, s_WE_O, s_LOCK_O, s_ADR_O, s_DAT_O, s_SEL_O,
           s_TGA_O, s_TGC_O, s_TGD_O,
    output s_DAT_I, s_TGD_I, s_ACK_I, s_ERR_I, s_RTY_I
  );
endinterface

// File: rtl/wb_rr_arbiter_pick.sv
// Combinational one-hot round-robin picker: next requester after last_i, wrapping.
module wb_rr_pick
  import wb_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  localparam int unsigned IDX_W      = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [IDX_W-1:0]       last_i,
  output logic [NUM_MASTERS-1:0] gnt_c_o
);

  logic [MAX_M-1:0] gnt_full;

  always_comb begin
    gnt_full = rr_search(MAX_M'(req_i), 32'(last_i), NUM_MASTERS);
    gnt_c_o  = NUM_MASTERS'(gnt_full);
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: registered grant held per cycle/lock, owner muxed
// onto one slave port, watchdog turns a stalled strobe into ERR.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADR_W       = 64,
  parameter int unsigned DAT_W       = 64,
  parameter int unsigned SEL_W       = DAT_W / 8,
  parameter int unsigned TAG_W       = 1,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                   CLK_I,
  input  logic                   RST_I,
  wb_rr_arbiter_if.arb           bus,
  output logic [NUM_MASTERS-1:0] gnt_o
);

  localparam int unsigned IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d, pick;
  logic [IDX_W-1:0]       last_q, last_d, owner_idx;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic                   own_cyc, own_stb, own_we, own_lock;
  logic [ADR_W-1:0]       own_adr;
  logic [DAT_W-1:0]       own_dat;
  logic [SEL_W-1:0]       own_sel;
  logic [TAG_W-1:0]       own_tga, own_tgc, own_tgd;
  logic                   term;

  wb_rr_pick #(.NUM_MASTERS(NUM_MASTERS)) u_pick (
    .req_i   (bus.m_CYC_I),
    .last_i  (last_q),
    .gnt_c_o (pick)
  );

  // Owner select: grant is one-hot, so a priority loop acts as a plain mux.
  always_comb begin
    own_cyc   = 1'b0;
    own_stb   = 1'b0;
    own_we    = 1'b0;
    own_lock  = 1'b0;
    own_adr   = '0;
    own_dat   = '0;
    own_sel   = '0;
    own_tga   = '0;
    own_tgc   = '0;
    own_tgd   = '0;
    owner_idx = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (gnt_q[i]) begin
        own_cyc   = bus.m_CYC_I[i];
        own_stb   = bus.m_STB_I[i];
        own_we    = bus.m_WE_I[i];
        own_lock  = bus.m_LOCK_I[i];
        own_adr   = bus.m_ADR_I[i*ADR_W +: ADR_W];
        own_dat   = bus.m_DAT_I[i*DAT_W +: DAT_W];
        own_sel   = bus.m_SEL_I[i*SEL_W +: SEL_W];
        own_tga   = bus.m_TGA_I[i*TAG_W +: TAG_W];
        own_tgc   = bus.m_TGC_I[i*TAG_W +: TAG_W];
        own_tgd   = bus.m_TGD_I[i*TAG_W +: TAG_W];
        owner_idx = IDX_W'(i);
      end
    end
  end

  assign term = bus.s_ACK_I | bus.s_ERR_I | bus.s_RTY_I;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (|bus.m_CYC_I) begin
          gnt_d   = pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!(own_cyc || own_lock)) begin
          gnt_d   = '0;
          last_d  = owner_idx;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (!own_stb || term) begin
          cnt_d = '0;
        end else if (TIMEOUT != 0) begin
          // Trip after TIMEOUT strobed cycles without any termination.
          if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            cnt_d   = '0;
            state_d = TOERR;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      TOERR: begin
        cnt_d   = '0;
        state_d = BUSY;
      end
      default: state_d = IDLE;
    endcase
  end

  // Slave drive and termination routing; read data is broadcast regardless of state.
  always_comb begin
    bus.s_CYC_O  = 1'b0;
    bus.s_STB_O  = 1'b0;
    bus.s_WE_O   = 1'b0;
    bus.s_LOCK_O = 1'b0;
    bus.s_ADR_O  = '0;
    bus.s_DAT_O  = '0;
    bus.s_SEL_O  = '0;
    bus.s_TGA_O  = '0;
    bus.s_TGC_O  = '0;
    bus.s_TGD_O  = '0;
    bus.m_ACK_O  = '0;
    bus.m_ERR_O  = '0;
    bus.m_RTY_O  = '0;
    bus.m_DAT_O  = bus.s_DAT_I;
    bus.m_TGD_O  = bus.s_TGD_I;
    if (state_q == BUSY) begin
      bus.s_CYC_O  = own_cyc;
      bus.s_STB_O  = own_stb;
      bus.s_WE_O   = own_we;
      bus.s_LOCK_O = own_lock;
      bus.s_ADR_O  = own_adr;
      bus.s_DAT_O  = own_dat;
      bus.s_SEL_O  = own_sel;
      bus.s_TGA_O  = own_tga;
      bus.s_TGC_O  = own_tgc;
      bus.s_TGD_O  = own_tgd;
      bus.m_ACK_O  = gnt_q & {NUM_MASTERS{bus.s_ACK_I}};
      bus.m_ERR_O  = gnt_q & {NUM_MASTERS{bus.s_ERR_I}};
      bus.m_RTY_O  = gnt_q & {NUM_MASTERS{bus.s_RTY_I}};
    end else if (state_q == TOERR) begin
      bus.m_ERR_O = gnt_q;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= IDX_W'(NUM_MASTERS - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt_o = gnt_q;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: two masters, TIMEOUT=4, fixed-cycle stimulus.
module tb_wb_rr_arbiter;

  localparam int unsigned NM = 2;
  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned SW = 8;
  localparam int unsigned TW = 1;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NM-1:0] gnt;
  int            n_tests = 0;
  int            n_fail  = 0;

  always #5 clk = ~clk;

  wb_rr_arbiter_if #(.NUM_MASTERS(NM), .ADR_W(AW), .DAT_W(DW), .SEL_W(SW), .TAG_W(TW)) bus ();

  wb_rr_arbiter #(
    .NUM_MASTERS(NM), .ADR_W(AW), .DAT_W(DW), .SEL_W(SW), .TAG_W(TW), .TIMEOUT(TO)
  ) dut (
    .CLK_I (clk),
    .RST_I (rst),
    .bus   (bus),
    .gnt_o (gnt)
  );

  // Each "window" starts 1 time unit after a rising edge; inputs set there are sampled next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    bus.m_CYC_I = '0; bus.m_STB_I = '0; bus.m_WE_I = '0; bus.m_LOCK_I = '0;
    bus.m_ADR_I = '0; bus.m_DAT_I = '0; bus.m_SEL_I = '0;
    bus.m_TGA_I = '0; bus.m_TGC_I = '0; bus.m_TGD_I = '0;
    bus.s_DAT_I = '0; bus.s_TGD_I = '0;
    bus.s_ACK_I = 1'b0; bus.s_ERR_I = 1'b0; bus.s_RTY_I = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    bus.s_DAT_I = 64'h1234_5678;
    bus.s_TGD_I = 1'b1;
    settle();
    n_tests++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b want 00", gnt); end
    n_tests++; if (bus.s_CYC_O !== 1'b0) begin n_fail++; $display("FAIL reset_scyc: got %b want 0", bus.s_CYC_O); end
    n_tests++; if (bus.s_STB_O !== 1'b0) begin n_fail++; $display("FAIL reset_sstb: got %b want 0", bus.s_STB_O); end
    n_tests++; if (bus.m_ACK_O !== 2'b00) begin n_fail++; $display("FAIL reset_ack: got %b want 00", bus.m_ACK_O); end
    n_tests++; if (bus.m_ERR_O !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b want 00", bus.m_ERR_O); end
    n_tests++; if (bus.m_RTY_O !== 2'b00) begin n_fail++; $display("FAIL reset_rty: got %b want 00", bus.m_RTY_O); end
    n_tests++; if (bus.m_DAT_O !== 64'h1234_5678) begin n_fail++; $display("FAIL reset_datpass: got %h want 12345678", bus.m_DAT_O); end
    n_tests++; if (bus.m_TGD_O !== 1'b1) begin n_fail++; $display("FAIL reset_tgdpass: got %b want 1", bus.m_TGD_O); end
    bus.s_DAT_I = '0;
    bus.s_TGD_I = '0;
  endtask

  task automatic test_single_write();
    tick();
    bus.m_CYC_I = 2'b01; bus.m_STB_I = 2'b01; bus.m_WE_I = 2'b01;
    bus.m_ADR_I[0 +: AW] = 64'h100;
    bus.m_DAT_I[0 +: DW] = 64'hDEAD_BEEF;
    bus.m_SEL_I[0 +: SW] = 8'hFF;
    settle();
    n_tests++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL wr_gnt_w0: got %b want 00", gnt); end
    n_tests++; if (bus.s_CYC_O !== 1'b0) begin n_fail++; $display("FAIL wr_scyc_w0: got %b want 0", bus.s_CYC_O); end
    tick(); settle();
    n_tests++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL wr_gnt_w1: got %b want 01", gnt); end
    n_tests++; if (bus.s_CYC_O !== 1'b1) begin n_fail++; $display("FAIL wr_scyc_w1: got %b want 1", bus.s_CYC_O); end
    n_tests++; if (bus.s_ADR_O !== 64'h100) begin n_fail++; $display("FAIL wr_adr: got %h want 100", bus.s_ADR_O); end
    n_tests++; if (bus.s_DAT_O !== 64'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_dat: got %h want deadbeef", bus.s_DAT_O); end
    n_tests++; if (bus.s_WE_O !== 1'b1) begin n_fail++; $display("FAIL wr_we: got %b want 1", bus.s_WE_O); end
    n_tests++; if (bus.s_SEL_O !== 8'hFF) begin n_fail++; $display("FAIL wr_sel: got %h want ff", bus.s_SEL_O); end
    n_tests++; if (bus.m_ACK_O !== 2'b00) begin n_fail++; $display("FAIL wr_ack_early: got %b want 00", bus.m_ACK_O); end
    tick();
    tick();
    bus.s_ACK_I = 1'b1;
    settle();
    n_tests++; if (bus.m_ACK_O !== 2'b01) begin n_fail++; $display("FAIL wr_ack: got %b want 01", bus.m_ACK_O); end
    tick();
    bus.s_ACK_I = 1'b0;
    clear_inputs();
    settle();
    n_tests++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL wr_gnt_rel: got %b want 01", gnt); end
    n_tests++; if (bus.s_CYC_O !== 1'b0) begin n_fail++; $display("FAIL wr_scyc_rel: got %b want 0", bus.s_CYC_O); end
    tick(); settle();
    n_tests++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL wr_gnt_idle: got %b want 00", gnt); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp;
    do_reset();
    tick();
    bus.m_CYC_I = 2'b11; bus.m_STB_I = 2'b11;
    settle();
    n_tests++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL rr_gnt_start: got %b want 00", gnt); end
    for (int k = 0; k < 6; k++) begin
      exp = (k % 2 == 0) ? 2'b01 : 2'b10;
      tick(); settle();
      n_tests++; if (gnt !== exp) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, gnt, exp); end
      bus.s_ACK_I = 1'b1;
      settle();
      n_tests++; if (bus.m_ACK_O !== exp) begin n_fail++; $display("FAIL rr_ack[%0d]: got %b want %b", k, bus.m_ACK_O, exp); end
      tick();
      bus.s_ACK_I = 1'b0;
      bus.m_CYC_I = ~exp; bus.m_STB_I = ~exp;
      settle();
      n_tests++; if (gnt !== exp) begin n_fail++; $display("FAIL rr_hold[%0d]: got %b want %b", k, gnt, exp); end
      n_tests++; if (bus.s_CYC_O !== 1'b0) begin n_fail++; $display("FAIL rr_scyc_rel[%0d]: got %b want 0", k, bus.s_CYC_O); end
      tick();
      bus.m_CYC_I = (k == 5) ? 2'b00 : 2'b11;
      bus.m_STB_I = bus.m_CYC_I;
      settle();
      n_tests++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL rr_idle[%0d]: got %b want 00", k, gnt); end
    end
  endtask

  task automatic test_lock();
    tick();
    bus.m_CYC_I = 2'b10; bus.m_STB_I = 2'b10; bus.m_LOCK_I = 2'b10;
    settle();
    n_tests++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL lk_gnt_w0: got %b want 00", gnt); end
    for (int r = 0; r < 4; r++) begin
      tick();
      bus.m_CYC_I = 2'b11; bus.m_STB_I = 2'b11;
      bus.s_ACK_I = 1'b1;
      bus.s_DAT_I = 64'hA000 + 64'(r);
      settle();
      n_tests++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL lk_gnt[%0d]: got %b want 10", r, gnt); end
      n_tests++; if (bus.m_ACK_O !== 2'b10) begin n_fail++; $display("FAIL lk_ack[%0d]: got %b want 10", r, bus.m_ACK_O); end
      n_tests++; if (bus.m_DAT_O !== 64'hA000 + 64'(r)) begin n_fail++; $display("FAIL lk_dat[%0d]: got %h want %h", r, bus.m_DAT_O, 64'hA000 + 64'(r)); end
      tick();
      bus.m_CYC_I = 2'b01; bus.m_STB_I = 2'b01;
      bus.s_ACK_I = 1'b0;
      settle();
      n_tests++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL lk_gap_gnt[%0d]: got %b want 10", r, gnt); end
      n_tests++; if (bus.m_ACK_O !== 2'b00) begin n_fail++; $display("FAIL lk_gap_ack[%0d]: got %b want 00", r, bus.m_ACK_O); end
    end
    tick();
    bus.m_LOCK_I = 2'b00;
    settle();
    n_tests++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL lk_rel_gnt: got %b want 10", gnt); end
    tick(); settle();
    n_tests++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL lk_idle_gnt: got %b want 00", gnt); end
    tick(); settle();
    n_tests++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL lk_m0_gnt: got %b want 01", gnt); end
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_timeout();
    tick();
    bus.m_CYC_I = 2'b01; bus.m_STB_I = 2'b01; bus.m_WE_I = 2'b01;
    settle();
    n_tests++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL to_gnt_w0: got %b want 00", gnt); end
    for (int c = 1; c <= 4; c++) begin
      tick(); settle();
      n_tests++; if (bus.s_STB_O !== 1'b1) begin n_fail++; $display("FAIL to_stb[%0d]: got %b want 1", c, bus.s_STB_O); end
      n_tests++; if (bus.m_ERR_O !== 2'b00) begin n_fail++; $display("FAIL to_noerr[%0d]: got %b want 00", c, bus.m_ERR_O); end
    end
    tick();
    bus.s_ACK_I = 1'b1;
    settle();
    n_tests++; if (bus.m_ERR_O !== 2'b01) begin n_fail++; $display("FAIL to_err: got %b want 01", bus.m_ERR_O); end
    n_tests++; if (bus.s_STB_O !== 1'b0) begin n_fail++; $display("FAIL to_stb_forced: got %b want 0", bus.s_STB_O); end
    n_tests++; if (bus.s_CYC_O !== 1'b0) begin n_fail++; $display("FAIL to_cyc_forced: got %b want 0", bus.s_CYC_O); end
    n_tests++; if (bus.m_ACK_O !== 2'b00) begin n_fail++; $display("FAIL to_ack_ignored: got %b want 00", bus.m_ACK_O); end
    tick();
    bus.s_ACK_I = 1'b0;
    settle();
    n_tests++; if (bus.s_STB_O !== 1'b1) begin n_fail++; $display("FAIL to_back_busy: got %b want 1", bus.s_STB_O); end
    n_tests++; if (bus.m_ERR_O !== 2'b00) begin n_fail++; $display("FAIL to_err_once: got %b want 00", bus.m_ERR_O); end
    n_tests++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL to_gnt_kept: got %b want 01", gnt); end
    tick();
    clear_inputs();
    tick(); settle();
    n_tests++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL to_gnt_rel: got %b want 00", gnt); end
  endtask

  task automatic test_retry();
    tick();
    bus.m_CYC_I = 2'b01; bus.m_STB_I = 2'b01;
    tick();
    bus.s_RTY_I = 1'b1;
    settle();
    n_tests++; if (bus.m_RTY_O !== 2'b01) begin n_fail++; $display("FAIL rty_rty: got %b want 01", bus.m_RTY_O); end
    n_tests++; if (bus.m_ACK_O !== 2'b00) begin n_fail++; $display("FAIL rty_ack: got %b want 00", bus.m_ACK_O); end
    tick();
    bus.s_RTY_I = 1'b0;
    settle();
    n_tests++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL rty_gnt_kept: got %b want 01", gnt); end
    n_tests++; if (bus.m_RTY_O !== 2'b00) begin n_fail++; $display("FAIL rty_clear: got %b want 00", bus.m_RTY_O); end
    tick();
    bus.s_ACK_I = 1'b1;
    settle();
    n_tests++; if (bus.m_ACK_O !== 2'b01) begin n_fail++; $display("FAIL rty_ack_after: got %b want 01", bus.m_ACK_O); end
    tick();
    clear_inputs();
    tick(); settle();
    n_tests++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL rty_gnt_rel: got %b want 00", gnt); end
  endtask

  task automatic test_reset_mid();
    tick();
    bus.m_CYC_I = 2'b11; bus.m_STB_I = 2'b11;
    tick(); settle();
    n_tests++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL rm_gnt_m1: got %b want 10", gnt); end
    n_tests++; if (bus.s_CYC_O !== 1'b1) begin n_fail++; $display("FAIL rm_scyc_busy: got %b want 1", bus.s_CYC_O); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    n_tests++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL rm_gnt_rst: got %b want 00", gnt); end
    n_tests++; if (bus.s_CYC_O !== 1'b0) begin n_fail++; $display("FAIL rm_scyc_rst: got %b want 0", bus.s_CYC_O); end
    n_tests++; if (bus.m_ACK_O !== 2'b00) begin n_fail++; $display("FAIL rm_ack_rst: got %b want 00", bus.m_ACK_O); end
    tick(); settle();
    n_tests++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL rm_m0_prio: got %b want 01", gnt); end
    clear_inputs();
    tick();
    tick();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_write();
    test_round_robin();
    test_lock();
    test_timeout();
    test_retry();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
